ysyx_2022040010_wb_stage: RTL and testbench

Write-back stage of the RV64 core, between the MEM stage and the register file. It captures one retiring instruction per handshake and formats load data (sign/zero extension, byte-lane select). It drives the register file write port (we/waddr/wdata) exactly once per committed instruction and exposes a commit port with back-pressure for the difftest/trace consumer. It also keeps a retired-instruction counter and halts the core on ebreak.

---
 rtl/ysyx_2022040010_wb_stage.sv | 140 ++++++++++++++
 tb/tb_ysyx_2022040010_wb_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_2022040010_wb_stage.sv
// rtl/ysyx_2022040010_wb_stage.sv - write-back stage: load formatting, regfile write, commit port, retire counter, ebreak halt
module ysyx_2022040010_wb_stage #(
  parameter int XLEN = 64,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic            in_rd_we,
  input  logic [AW-1:0]   in_rd,
  input  logic [XLEN-1:0] in_alu_res,
  input  logic            in_is_load,
  input  logic [2:0]      in_ld_funct3,
  input  logic [2:0]      in_ld_off,
  input  logic [XLEN-1:0] in_mem_rdata,
  input  logic            in_ebreak,
  output logic            we,
  output logic [AW-1:0]   waddr,
  output logic [XLEN-1:0] wdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [63:0]     retire_cnt,
  output logic            halted
);

  typedef enum logic [1:0] {EMPTY, FULL, HALT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic            rd_we_q, rd_we_d;
  logic [XLEN-1:0] wval_q, wval_d;
  logic            ebreak_q, ebreak_d;
  logic [63:0]     retire_cnt_q, retire_cnt_d;

  logic            is_full;
  logic            accept;
  logic            commit;
  logic [XLEN-1:0] ld_sh;
  logic [XLEN-1:0] ld_val;
  logic [XLEN-1:0] new_wval;

  // Handshake terms; reset forces the stage invisible to both neighbours.
  always_comb begin
    is_full  = (state_q == FULL) && !rst;
    in_ready = !rst && ((state_q == EMPTY) ||
                        ((state_q == FULL) && out_ready && !ebreak_q));
    accept   = in_valid && in_ready;
    commit   = is_full && out_ready;
  end

  // Load data: shift the addressed lane down to bit 0, then extend per funct3.
  always_comb begin
    ld_sh = in_mem_rdata >> {in_ld_off, 3'b000};
    case (in_ld_funct3)
      3'b000:  ld_val = {{(XLEN-8){ld_sh[7]}},   ld_sh[7:0]};
      3'b001:  ld_val = {{(XLEN-16){ld_sh[15]}}, ld_sh[15:0]};
      3'b010:  ld_val = {{(XLEN-32){ld_sh[31]}}, ld_sh[31:0]};
      3'b011:  ld_val = ld_sh;
      3'b100:  ld_val = {{(XLEN-8){1'b0}},  ld_sh[7:0]};
      3'b101:  ld_val = {{(XLEN-16){1'b0}}, ld_sh[15:0]};
      3'b110:  ld_val = {{(XLEN-32){1'b0}}, ld_sh[31:0]};
      default: ld_val = '0;
    endcase
    new_wval = in_is_load ? ld_val : in_alu_res;
  end

  // Next-state: capture on accept, retire on commit, freeze after ebreak.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    rd_d         = rd_q;
    rd_we_d      = rd_we_q;
    wval_d       = wval_q;
    ebreak_d     = ebreak_q;
    retire_cnt_d = commit ? retire_cnt_q + 64'd1 : retire_cnt_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (commit) begin
          if (ebreak_q)    state_d = HALT;
          else if (accept) state_d = FULL;
          else             state_d = EMPTY;
        end
      end
      default: state_d = HALT;
    endcase
    if (accept) begin
      pc_d     = in_pc;
      inst_d   = in_inst;
      rd_d     = in_rd;
      rd_we_d  = in_rd_we;
      wval_d   = new_wval;
      ebreak_d = in_ebreak;
    end
  end

  // State and holding register; reset clears everything and drops any held instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      pc_q         <= '0;
      inst_q       <= '0;
      rd_q         <= '0;
      rd_we_q      <= 1'b0;
      wval_q       <= '0;
      ebreak_q     <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      rd_q         <= rd_d;
      rd_we_q      <= rd_we_d;
      wval_q       <= wval_d;
      ebreak_q     <= ebreak_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Register-file write port is live in the commit cycle so the bypass sees it.
  always_comb begin
    we         = commit && rd_we_q && (rd_q != '0);
    waddr      = is_full ? rd_q : '0;
    wdata      = is_full ? wval_q : '0;
    out_valid  = is_full;
    out_pc     = pc_q;
    out_inst   = inst_q;
    retire_cnt = retire_cnt_q;
    halted     = (state_q == HALT) && !rst;
  end

endmodule

// File: tb/tb_ysyx_2022040010_wb_stage.sv
// tb/tb_ysyx_2022040010_wb_stage.sv - scoreboard bench for the write-back stage
module tb_ysyx_2022040010_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_inst;
  logic        in_rd_we;
  logic [4:0]  in_rd;
  logic [63:0] in_alu_res;
  logic        in_is_load;
  logic [2:0]  in_ld_funct3;
  logic [2:0]  in_ld_off;
  logic [63:0] in_mem_rdata;
  logic        in_ebreak;
  logic        we;
  logic [4:0]  waddr;
  logic [63:0] wdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic [63:0] retire_cnt;
  logic        halted;

  ysyx_2022040010_wb_stage #(.XLEN(64), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_rd_we(in_rd_we), .in_rd(in_rd),
    .in_alu_res(in_alu_res), .in_is_load(in_is_load), .in_ld_funct3(in_ld_funct3),
    .in_ld_off(in_ld_off), .in_mem_rdata(in_mem_rdata), .in_ebreak(in_ebreak),
    .we(we), .waddr(waddr), .wdata(wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst),
    .retire_cnt(retire_cnt), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        we;
    logic [4:0]  rd;
    logic [63:0] wdata;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_writes = 0;
  int   last_we_cyc = 0;
  int   prev_we_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every commit handshake pops the oldest expectation and compares.
  always @(negedge clk) begin
    exp_t e;
    if (we && !(out_valid && out_ready)) begin
      n_checks++;
      n_fail++;
      $display("FAIL we_outside_commit: got we=1 expected we=0");
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_commit: got pc=%h expected no commit", out_pc);
      end else begin
        e = q.pop_front();
        chk("commit_pc", out_pc, e.pc);
        chk("commit_inst", {32'd0, out_inst}, {32'd0, e.inst});
        chk("commit_we", {63'd0, we}, {63'd0, e.we});
        if (e.we) begin
          chk("commit_waddr", {59'd0, waddr}, {59'd0, e.rd});
          chk("commit_wdata", wdata, e.wdata);
        end
      end
      if (we) begin
        n_writes++;
        prev_we_cyc = last_we_cyc;
        last_we_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [63:0] pc, input logic rd_we, input logic [4:0] rd,
                            input logic [63:0] alu, input logic is_load, input logic [2:0] f3,
                            input logic [2:0] off, input logic [63:0] rdata, input logic ebr);
    in_pc        = pc;
    in_inst      = pc[31:0] ^ 32'h0000_0013;
    in_rd_we     = rd_we;
    in_rd        = rd;
    in_alu_res   = alu;
    in_is_load   = is_load;
    in_ld_funct3 = f3;
    in_ld_off    = off;
    in_mem_rdata = rdata;
    in_ebreak    = ebr;
    in_valid     = 1'b1;
  endtask

  // Present one instruction and wait (bounded) for it to be accepted.
  task automatic issue(input logic [63:0] pc, input logic rd_we, input logic [4:0] rd,
                       input logic [63:0] alu, input logic is_load, input logic [2:0] f3,
                       input logic [2:0] off, input logic [63:0] rdata, input logic ebr,
                       input logic exp_we, input logic [63:0] exp_w, input logic commits);
    exp_t e;
    set_fields(pc, rd_we, rd, alu, is_load, f3, off, rdata, ebr);
    e.pc = pc; e.inst = pc[31:0] ^ 32'h0000_0013; e.we = exp_we; e.rd = rd; e.wdata = exp_w;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (commits) q.push_back(e);
        step();
        in_valid = 1'b0;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL accept_timeout: got in_ready=0 expected accept of pc=%h", pc);
    in_valid = 1'b0;
  endtask

  task automatic alu_op(input logic [63:0] pc, input logic [4:0] rd, input logic [63:0] v,
                        input logic exp_we, input logic commits);
    issue(pc, 1'b1, rd, v, 1'b0, 3'd0, 3'd0, 64'd0, 1'b0, exp_we, v, commits);
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!out_valid) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL drain_timeout: got out_valid=1 expected 0");
  endtask

  localparam logic [63:0] MEMW = 64'h8877_6655_4433_2211;

  typedef struct packed {
    logic [2:0]  f3;
    logic [2:0]  off;
    logic [63:0] exp;
  } ld_t;

  ld_t ld_tab[8];

  initial begin
    logic [63:0] rc;
    int wc;
    ld_tab[0] = '{3'b000, 3'd7, 64'hFFFF_FFFF_FFFF_FF88};
    ld_tab[1] = '{3'b100, 3'd7, 64'h0000_0000_0000_0088};
    ld_tab[2] = '{3'b001, 3'd6, 64'hFFFF_FFFF_FFFF_8877};
    ld_tab[3] = '{3'b110, 3'd4, 64'h0000_0000_8877_6655};
    ld_tab[4] = '{3'b010, 3'd0, 64'h0000_0000_4433_2211};
    ld_tab[5] = '{3'b011, 3'd0, 64'h8877_6655_4433_2211};
    ld_tab[6] = '{3'b101, 3'd2, 64'h0000_0000_0000_4433};
    ld_tab[7] = '{3'b111, 3'd0, 64'h0000_0000_0000_0000};

    rst = 1'b1;
    out_ready = 1'b1;
    set_fields(64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 3'd0, 3'd0, 64'd0, 1'b0);
    in_valid = 1'b0;
    step();
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_we", {63'd0, we}, 64'd0);
    chk("rst_wdata", wdata, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_retire", retire_cnt, 64'd0);
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    step();

    alu_op(64'h1000, 5'd5, 64'h1234, 1'b1, 1'b1);
    alu_op(64'h1004, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    drain();
    chk("b2b_retire", retire_cnt, 64'd2);
    chk("b2b_consecutive", 64'(last_we_cyc - prev_we_cyc), 64'd1);
    step();

    for (int i = 0; i < 8; i++)
      issue(64'h2000 + 64'(i * 4), 1'b1, 5'(10 + i), 64'hDEAD, 1'b1, ld_tab[i].f3,
            ld_tab[i].off, MEMW, 1'b0, 1'b1, ld_tab[i].exp, 1'b1);
    drain();
    chk("load_retire", retire_cnt, 64'd10);
    step();

    out_ready = 1'b0;
    alu_op(64'h100, 5'd7, 64'hAAAA, 1'b1, 1'b1);
    rc = retire_cnt;
    wc = n_writes;
    set_fields(64'h104, 1'b1, 5'd8, 64'hBBBB, 1'b0, 3'd0, 3'd0, 64'd0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_out_pc", out_pc, 64'h100);
      chk("bp_we", {63'd0, we}, 64'd0);
      chk("bp_retire", retire_cnt, rc);
    end
    step();
    out_ready = 1'b1;
    alu_op(64'h104, 5'd8, 64'hBBBB, 1'b1, 1'b1);
    chk("bp_one_write", 64'(n_writes - wc), 64'd1);
    chk("bp_next_held", out_pc, 64'h104);
    drain();
    step();

    rc = retire_cnt;
    alu_op(64'h200, 5'd0, 64'h5555, 1'b0, 1'b1);
    drain();
    chk("x0_retire", retire_cnt, rc + 64'd1);
    step();

    rc = retire_cnt;
    issue(64'h300, 1'b0, 5'd0, 64'd0, 1'b0, 3'd0, 3'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1);
    set_fields(64'h304, 1'b1, 5'd9, 64'h9999, 1'b0, 3'd0, 3'd0, 64'd0, 1'b0);
    @(negedge clk);
    chk("ebreak_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    chk("halt_halted", {63'd0, halted}, 64'd1);
    chk("halt_out_valid", {63'd0, out_valid}, 64'd0);
    chk("halt_retire", retire_cnt, rc + 64'd1);
    repeat (3) begin
      @(negedge clk);
      chk("halt_in_ready", {63'd0, in_ready}, 64'd0);
    end
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("unhalt_halted", {63'd0, halted}, 64'd0);
    chk("unhalt_retire", retire_cnt, 64'd0);
    step();

    out_ready = 1'b0;
    alu_op(64'h400, 5'd3, 64'h7777, 1'b1, 1'b0);
    @(negedge clk);
    chk("mid_full", {63'd0, out_valid}, 64'd1);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_we", {63'd0, we}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_retire", retire_cnt, 64'd0);
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
